// File: rtl/mesh_term_bridge.sv
// mesh_term_bridge: host <-> 4x4 mesh terminal bridge.
// Each terminal lane has an egress FIFO (host -> router) and an ingress FIFO
// (router -> host), both first-word-fall-through, plus saturating tx/rx/drop
// counters. Lanes are independent and share nothing but the counter readback mux.

// Per-terminal lane: egress FIFO, ingress FIFO and the three event counters.
module mesh_term_lane #(
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [PAKG_SIZE-1:0] push_data_i,
    output logic                 full_o,
    output logic                 pndng,
    output logic [PAKG_SIZE-1:0] data_out,
    input  logic                 pop,
    input  logic                 pndng_i_in,
    input  logic [PAKG_SIZE-1:0] data_out_i_in,
    output logic                 popin,
    input  logic                 rd_en_i,
    output logic [PAKG_SIZE-1:0] rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 en_i,
    output logic [15:0]          tx_cnt,
    output logic [15:0]          rx_cnt,
    output logic [15:0]          drop_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [PAKG_SIZE-1:0] e_mem [FIFO_DEPTH];
    logic [PAKG_SIZE-1:0] i_mem [FIFO_DEPTH];
    logic [PW-1:0]        e_wr_ptr, e_rd_ptr, i_wr_ptr, i_rd_ptr;
    logic [CW-1:0]        e_occ, i_occ;
    logic                 e_push_ok, e_pop_ok, e_drop, i_full, i_wr, i_rd;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Egress/ingress handshakes; a full egress FIFO still accepts a push when
    // the head is popped in the same cycle (the freed slot is the one written).
    always_comb begin
        full_o     = (e_occ == DEPTH_C);
        pndng      = (e_occ != '0);
        e_pop_ok   = pop & pndng;
        e_push_ok  = push_i & (~full_o | pop);
        e_drop     = push_i & full_o & ~pop;
        i_full     = (i_occ == DEPTH_C);
        rd_valid_o = (i_occ != '0);
        popin      = pndng_i_in & en_i & ~i_full & rst_i;
        i_wr       = popin;
        i_rd       = rd_en_i & rd_valid_o;
        data_out   = e_mem[e_rd_ptr];
        rd_data_o  = i_mem[i_rd_ptr];
    end

    // Pointers, occupancy and counters; cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            e_wr_ptr <= '0;
            e_rd_ptr <= '0;
            e_occ    <= '0;
            i_wr_ptr <= '0;
            i_rd_ptr <= '0;
            i_occ    <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (e_push_ok) e_wr_ptr <= e_wr_ptr + 1'b1;
            if (e_pop_ok)  e_rd_ptr <= e_rd_ptr + 1'b1;
            e_occ    <= e_occ + CW'(e_push_ok) - CW'(e_pop_ok);
            if (i_wr) i_wr_ptr <= i_wr_ptr + 1'b1;
            if (i_rd) i_rd_ptr <= i_rd_ptr + 1'b1;
            i_occ    <= i_occ + CW'(i_wr) - CW'(i_rd);
            tx_cnt   <= sat_inc(tx_cnt, e_pop_ok);
            rx_cnt   <= sat_inc(rx_cnt, i_wr);
            drop_cnt <= sat_inc(drop_cnt, e_drop);
        end
    end

    // Storage writes; contents are don't-care after reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (e_push_ok) e_mem[e_wr_ptr] <= push_data_i;
        if (i_wr)      i_mem[i_wr_ptr] <= data_out_i_in;
    end
endmodule

// Top: array of independent lanes plus counter readback mux.
module mesh_term_bridge #(
    parameter int NUM_TERM   = 16,
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_TERM-1:0]           push_i,
    input  logic [NUM_TERM*PAKG_SIZE-1:0] push_data_i,
    output logic [NUM_TERM-1:0]           full_o,
    output logic [NUM_TERM-1:0]           pndng,
    output logic [NUM_TERM*PAKG_SIZE-1:0] data_out,
    input  logic [NUM_TERM-1:0]           pop,
    input  logic [NUM_TERM-1:0]           pndng_i_in,
    input  logic [NUM_TERM*PAKG_SIZE-1:0] data_out_i_in,
    output logic [NUM_TERM-1:0]           popin,
    input  logic [NUM_TERM-1:0]           rd_en_i,
    output logic [NUM_TERM*PAKG_SIZE-1:0] rd_data_o,
    output logic [NUM_TERM-1:0]           rd_valid_o,
    input  logic [NUM_TERM-1:0]           en_i,
    input  logic [$clog2(NUM_TERM)-1:0]   cnt_sel_i,
    output logic [15:0]                   tx_cnt_o,
    output logic [15:0]                   rx_cnt_o,
    output logic [15:0]                   drop_cnt_o
);
    logic [NUM_TERM-1:0][15:0] tx_cnt, rx_cnt, drop_cnt;

    for (genvar g = 0; g < NUM_TERM; g++) begin : g_lane
        mesh_term_lane #(.PAKG_SIZE(PAKG_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_lane (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .push_i       (push_i[g]),
            .push_data_i  (push_data_i[g*PAKG_SIZE +: PAKG_SIZE]),
            .full_o       (full_o[g]),
            .pndng        (pndng[g]),
            .data_out     (data_out[g*PAKG_SIZE +: PAKG_SIZE]),
            .pop          (pop[g]),
            .pndng_i_in   (pndng_i_in[g]),
            .data_out_i_in(data_out_i_in[g*PAKG_SIZE +: PAKG_SIZE]),
            .popin        (popin[g]),
            .rd_en_i      (rd_en_i[g]),
            .rd_data_o    (rd_data_o[g*PAKG_SIZE +: PAKG_SIZE]),
            .rd_valid_o   (rd_valid_o[g]),
            .en_i         (en_i[g]),
            .tx_cnt       (tx_cnt[g]),
            .rx_cnt       (rx_cnt[g]),
            .drop_cnt     (drop_cnt[g])
        );
    end

    // Counter readback for the selected lane.
    always_comb begin
        tx_cnt_o   = tx_cnt[cnt_sel_i];
        rx_cnt_o   = rx_cnt[cnt_sel_i];
        drop_cnt_o = drop_cnt[cnt_sel_i];
    end
endmodule

// File: tb/tb_mesh_term_bridge.sv
// Testbench for mesh_term_bridge: table-driven egress vectors, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_mesh_term_bridge;
    localparam int NT = 16;
    localparam int PS = 32;
    localparam int D  = 16;
    localparam int SW = $clog2(NT);

    logic              clk = 1'b0;
    logic              rst;
    logic [NT-1:0]     push, full, pndng, pop, pndng_in, popin, rd_en, rd_valid, en;
    logic [NT*PS-1:0]  push_data, data_out, din, rd_data;
    logic [SW-1:0]     cnt_sel;
    logic [15:0]       tx_cnt, rx_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [PS-1:0] eq [NT][$];
    logic [PS-1:0] iq [NT][$];
    int m_tx [NT];
    int m_rx [NT];
    int m_drop [NT];

    typedef struct {
        logic          push;
        logic          pop;
        logic [PS-1:0] data;
        logic          exp_pndng;
        logic [PS-1:0] exp_head;
        logic [15:0]   exp_tx;
        logic [15:0]   exp_drop;
    } vec_t;
    vec_t tbl [6];

    mesh_term_bridge #(.NUM_TERM(NT), .PAKG_SIZE(PS), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_data_i(push_data),
        .full_o(full), .pndng(pndng), .data_out(data_out), .pop(pop),
        .pndng_i_in(pndng_in), .data_out_i_in(din), .popin(popin),
        .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .en_i(en),
        .cnt_sel_i(cnt_sel), .tx_cnt_o(tx_cnt), .rx_cnt_o(rx_cnt), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        push = '0; pop = '0; pndng_in = '0; rd_en = '0; en = '0;
        push_data = '0; din = '0; cnt_sel = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int l = 0; l < NT; l++) begin
            eq[l].delete(); iq[l].delete();
            m_tx[l] = 0; m_rx[l] = 0; m_drop[l] = 0;
        end
    endtask

    // Reset asserted away from a clock edge, released at posedge+1.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic int sat(input int v);
        return (v > 16'hFFFF) ? 16'hFFFF : v;
    endfunction

    // Compare every visible output against the model (called between edges).
    task automatic model_compare();
        logic [NT-1:0] e_pnd, e_full, e_rv, e_popin;
        for (int l = 0; l < NT; l++) begin
            e_pnd[l]   = eq[l].size() != 0;
            e_full[l]  = eq[l].size() == D;
            e_rv[l]    = iq[l].size() != 0;
            e_popin[l] = pndng_in[l] & en[l] & (iq[l].size() < D);
            if (e_pnd[l]) chk("rand_data_out", data_out[l*PS +: PS], eq[l][0]);
            if (e_rv[l])  chk("rand_rd_data", rd_data[l*PS +: PS], iq[l][0]);
        end
        chk("rand_pndng", pndng, e_pnd);
        chk("rand_full", full, e_full);
        chk("rand_rd_valid", rd_valid, e_rv);
        chk("rand_popin", popin, e_popin);
        chk("rand_tx", tx_cnt, sat(m_tx[cnt_sel]));
        chk("rand_rx", rx_cnt, sat(m_rx[cnt_sel]));
        chk("rand_drop", drop_cnt, sat(m_drop[cnt_sel]));
    endtask

    // Apply one clock's worth of the current inputs to the model.
    task automatic model_update();
        for (int l = 0; l < NT; l++) begin
            bit pop_ok, acc, wr, rd;
            pop_ok = pop[l] && eq[l].size() > 0;
            acc    = push[l] && (eq[l].size() < D || pop_ok);
            if (pop_ok) begin void'(eq[l].pop_front()); m_tx[l]++; end
            if (acc) eq[l].push_back(push_data[l*PS +: PS]);
            if (push[l] && !acc) m_drop[l]++;
            wr = pndng_in[l] && en[l] && iq[l].size() < D;
            rd = rd_en[l] && iq[l].size() > 0;
            if (rd) void'(iq[l].pop_front());
            if (wr) begin iq[l].push_back(din[l*PS +: PS]); m_rx[l]++; end
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 1'b0, 32'h1111_0004, 1'b1, 32'h1111_0004, 16'd0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h2222_0004, 1'b1, 32'h1111_0004, 16'd0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 32'h0,         1'b1, 32'h2222_0004, 16'd1, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 32'h3333_0004, 1'b1, 32'h3333_0004, 16'd2, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         16'd3, 16'd0};
        tbl[5] = '{1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         16'd3, 16'd0};

        // reset state, with router offering packets to every lane
        clear_inputs();
        rst = 1'b0;
        pndng_in = '1; en = '1;
        #3;
        chk("rst_pndng", pndng, 0);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_popin", popin, 0);
        chk("rst_tx", tx_cnt, 0);
        chk("rst_rx", rx_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        do_reset();

        // single push on lane 3, latency 1
        push[3] = 1'b1; push_data[3*PS +: PS] = 32'hA5A5_0003;
        #1 chk("push3_not_yet", pndng, 0);
        step();
        push = '0;
        chk("push3_pndng", pndng, 16'h0008);
        chk("push3_data", data_out[3*PS +: PS], 32'hA5A5_0003);

        // table-driven egress sequence on lane 4
        do_reset();
        cnt_sel = 4;
        for (int k = 0; k < 6; k++) begin
            push[4] = tbl[k].push; pop[4] = tbl[k].pop;
            push_data[4*PS +: PS] = tbl[k].data;
            step();
            push = '0; pop = '0;
            chk($sformatf("tbl%0d_pndng", k), pndng[4], tbl[k].exp_pndng);
            if (tbl[k].exp_pndng) chk($sformatf("tbl%0d_head", k), data_out[4*PS +: PS], tbl[k].exp_head);
            chk($sformatf("tbl%0d_tx", k), tx_cnt, tbl[k].exp_tx);
            chk($sformatf("tbl%0d_drop", k), drop_cnt, tbl[k].exp_drop);
        end

        // overflow lane 0: 17 pushes, one dropped, 16 read back in order
        do_reset();
        cnt_sel = 0;
        for (int k = 1; k <= 17; k++) begin
            push[0] = 1'b1; push_data[PS-1:0] = PS'(k);
            step();
            if (k == 15) chk("ovf_not_full15", full[0], 0);
            if (k == 16) chk("ovf_full16", full[0], 1);
        end
        push = '0;
        chk("ovf_drop", drop_cnt, 1);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("ovf_order%0d", k), data_out[PS-1:0], PS'(k));
            pop[0] = 1'b1;
            step();
        end
        pop = '0;
        chk("ovf_empty", pndng[0], 0);
        chk("ovf_tx", tx_cnt, 16);
        pop[0] = 1'b1; step(); pop = '0;
        chk("ovf_pop_empty_tx", tx_cnt, 16);

        // lane 5 full, push and pop together
        do_reset();
        cnt_sel = 5;
        for (int k = 1; k <= 16; k++) begin
            push[5] = 1'b1; push_data[5*PS +: PS] = PS'(k);
            step();
        end
        push[5] = 1'b1; pop[5] = 1'b1; push_data[5*PS +: PS] = 32'h99;
        step();
        push = '0; pop = '0;
        chk("fpp_full", full[5], 1);
        chk("fpp_drop", drop_cnt, 0);
        chk("fpp_tx", tx_cnt, 1);
        chk("fpp_head", data_out[5*PS +: PS], 2);

        // ingress lane 2 held pending for 20 cycles
        do_reset();
        cnt_sel = 2;
        pndng_in[2] = 1'b1; en[2] = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            din[2*PS +: PS] = PS'(100 + c);
            #1 if (popin[2]) n++;
            step();
        end
        chk("ing_popin_cycles", n, 16);
        chk("ing_popin_off", popin[2], 0);
        chk("ing_rx", rx_cnt, 16);
        chk("ing_head", rd_data[2*PS +: PS], 100);
        pndng_in = '0;
        rd_en[2] = 1'b1; step(); rd_en = '0;
        chk("ing_head2", rd_data[2*PS +: PS], 101);

        // enable gating on lane 7
        do_reset();
        cnt_sel = 7;
        pndng_in[7] = 1'b1; en[7] = 1'b0;
        #1 chk("en_off_popin", popin[7], 0);
        step(); step();
        chk("en_off_rx", rx_cnt, 0);
        en[7] = 1'b1;
        #1 chk("en_on_popin", popin[7], 1);
        step();
        chk("en_on_rx", rx_cnt, 1);

        // mid-cycle reset on a busy lane 1
        do_reset();
        cnt_sel = 1;
        for (int k = 0; k < 8; k++) begin
            push[1] = 1'b1; push_data[1*PS +: PS] = PS'(k);
            step();
        end
        push = '0;
        pop[1] = 1'b1; step(); step(); pop = '0;
        chk("mrst_tx_before", tx_cnt, 2);
        #3 rst = 1'b0;
        #1;
        chk("mrst_pndng", pndng[1], 0);
        chk("mrst_tx", tx_cnt, 0);
        chk("mrst_full", full, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("mrst_no_reappear", pndng[1], 0);

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < NT; l++) begin
                push_data[l*PS +: PS] = $urandom;
                din[l*PS +: PS] = $urandom;
            end
            push     = NT'($urandom);
            pndng_in = NT'($urandom);
            en       = NT'($urandom | $urandom);
            if (c < 1500) begin
                pop   = NT'($urandom & $urandom);
                rd_en = NT'($urandom & $urandom);
            end else begin
                pop   = NT'($urandom | $urandom);
                rd_en = NT'($urandom | $urandom);
            end
            cnt_sel = SW'($urandom);
            #1;
            model_compare();
            model_update();
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesh_term_bridge.md
MESH_TERM_BRIDGE -- requirements
Module: mesh_term_bridge

Interface
REQ-001 The block SHALL have parameter NUM_TERM, default 16, meaning number of mesh terminals served (ROWS*COLUMNS of the 4x4 mesh).
REQ-002 The block SHALL have parameter PAKG_SIZE, default 32, meaning packet width in bits.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning entries per egress and per ingress FIFO (power of 2, >=2).
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock; all state on rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port push_i, input, NUM_TERM bits: host write strobe per terminal egress FIFO.
REQ-007 The block SHALL have port push_data_i, input, NUM_TERM*PAKG_SIZE bits: host packet, lane i = [i*PAKG_SIZE +: PAKG_SIZE].
REQ-008 The block SHALL have port full_o, output, NUM_TERM bits: egress FIFO i full.
REQ-009 The block SHALL have port pndng, output, NUM_TERM bits: egress FIFO i non-empty, toward router.
REQ-010 The block SHALL have port data_out, output, NUM_TERM*PAKG_SIZE bits: egress head packet per lane.
REQ-011 The block SHALL have port pop, input, NUM_TERM bits: router consumes egress head.
REQ-012 The block SHALL have port pndng_i_in, input, NUM_TERM bits: router has packet for terminal i.
REQ-013 The block SHALL have port data_out_i_in, input, NUM_TERM*PAKG_SIZE bits: router packet per lane.
REQ-014 The block SHALL have port popin, output, NUM_TERM bits: block accepts router packet.
REQ-015 The block SHALL have port rd_en_i, input, NUM_TERM bits: host reads ingress head.
REQ-016 The block SHALL have port rd_data_o, output, NUM_TERM*PAKG_SIZE bits: ingress head packet.
REQ-017 The block SHALL have port rd_valid_o, output, NUM_TERM bits: ingress FIFO i non-empty.
REQ-018 The block SHALL have port en_i, input, NUM_TERM bits: per-terminal ingress accept enable.
REQ-019 The block SHALL have port cnt_sel_i, input, $clog2(NUM_TERM) bits: counter readback lane select.
REQ-020 The block SHALL have ports tx_cnt_o, rx_cnt_o, drop_cnt_o, output, 16 bits each: counters of lane cnt_sel_i, combinational mux.

Function
REQ-021 Each egress FIFO SHALL be first-word-fall-through: data_out lane = head entry, valid whenever pndng[i]=1; don't-care value when empty.
REQ-022 A push_i[i] with full_o[i]=0 SHALL write the lane data at the rising edge; visible on pndng/data_out the next cycle (latency 1).
REQ-023 A push_i[i] with full_o[i]=1 and pop[i]=0 SHALL be discarded and SHALL increment drop_cnt[i].
REQ-024 Simultaneous push_i[i] and pop[i] on a full FIFO SHALL both succeed; occupancy unchanged, no drop.
REQ-025 pop[i] on an empty egress FIFO SHALL be ignored; no pointer or counter change.
REQ-026 Each accepted pop[i] SHALL increment tx_cnt[i].
REQ-027 popin[i] SHALL be combinational: pndng_i_in[i] & en_i[i] & ~ingress_full[i]; with popin[i]=1 data_out_i_in lane is written that edge.
REQ-028 Ingress simultaneous write and rd_en_i[i] when full SHALL NOT occur since popin deasserts on full; write-read when non-full SHALL both succeed.
REQ-029 Each ingress write SHALL increment rx_cnt[i]; rd_en_i[i] on empty ingress SHALL be ignored.
REQ-030 Ingress FIFOs SHALL be FWFT: rd_data_o lane valid whenever rd_valid_o[i]=1.
REQ-031 All counters SHALL saturate at 16'hFFFF.
REQ-032 Pointers SHALL be $clog2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH; full/empty via separate occupancy count 0..FIFO_DEPTH.
REQ-033 Lanes SHALL be fully independent; no lane's activity affects another's state.

Reset
REQ-034 rst_i=0 SHALL immediately clear all pointers, occupancy and counters: pndng=0, full_o=0, rd_valid_o=0, popin=0, counters=0.
REQ-035 Reset asserted mid-operation SHALL discard all FIFO contents; no packet reappears after release.
REQ-036 FIFO storage arrays SHALL NOT require reset.

Verification
REQ-037 Reset, push lane 3 data 32'hA5A5_0003 -> next cycle pndng[3]=1, data_out lane 3=32'hA5A5_0003, other lanes pndng=0.
REQ-038 Push 17 packets lane 0 (FIFO_DEPTH=16), no pop -> full_o[0]=1 after 16th, drop_cnt(lane 0)=1, popping returns packets 1..16 in order.
REQ-039 Lane 5 full, push+pop same cycle -> full_o[5] stays 1, drop_cnt=0, tx_cnt=1.
REQ-040 pndng_i_in[2]=1 held 20 cycles, no rd_en_i, en_i[2]=1 -> popin[2] high exactly 16 cycles, then 0; rx_cnt(lane 2)=16.
REQ-041 en_i[7]=0 with pndng_i_in[7]=1 -> popin[7]=0, rx_cnt=0; set en_i[7]=1 -> popin[7]=1 same cycle.
REQ-042 Fill egress lane 1 with 8 packets, assert rst_i=0 between edges -> pndng[1]=0 and counters=0 immediately, before next clock edge.
